// File: rtl/step_ctrl_pkg.sv
// step_ctrl_pkg: shared step-controller state encodings and default timing constants.
package step_ctrl_pkg;
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_REL = 2'd1,
      RUN      = 2'd2
   } state_t;
   localparam int DEBOUNCE_N_DEF = 200000;
   localparam int RUN_DIV_DEF    = 50000000;
endpackage

// File: rtl/step_ctrl_debounce.sv
// btn_debounce: 2-flop synchronizer plus stable-count debouncer with a registered rising-edge strobe.
module btn_debounce
   import step_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_N = DEBOUNCE_N_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic rise
);
   localparam int CW = $clog2(DEBOUNCE_N + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_N - 1);
   logic [1:0] sync;
   logic [CW-1:0] cnt;
   logic flip;
   // flip once the synchronized input has disagreed for DEBOUNCE_N consecutive cycles
   assign flip = (sync[1] != level) && (cnt == CNT_LAST);
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         sync  <= '0;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
      end else begin
         sync  <= {sync[0], raw};
         cnt   <= (sync[1] == level || flip) ? '0 : cnt + CW'(1);
         level <= flip ? sync[1] : level;
         rise  <= flip && sync[1];
      end
endmodule

// File: rtl/step_ctrl.sv
// step_ctrl: single-step / free-run processor enable generator with debounced controls and a step counter.
module step_ctrl
   import step_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_N = DEBOUNCE_N_DEF,
   parameter int RUN_DIV    = RUN_DIV_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_step,
   input  logic        sw_run,
   output logic        cpu_en,
   output logic [15:0] step_cnt,
   output logic        mode_run
);
   localparam int DW = $clog2(RUN_DIV + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);
   state_t state, state_d;
   logic [DW-1:0] div, div_d;
   logic btn_level, btn_rise, run_rise, pulse;

   btn_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_btn (
      .clk(clk), .reset(reset), .raw(btn_step), .level(btn_level), .rise(btn_rise)
   );
   btn_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_run (
      .clk(clk), .reset(reset), .raw(sw_run), .level(mode_run), .rise(run_rise)
   );

   // run mode has priority; leaving RUN never pulses, so a terminal count there is dropped
   always_comb begin
      state_d = state;
      div_d   = '0;
      pulse   = 1'b0;
      if (mode_run) begin
         state_d = RUN;
         if (state == RUN && !run_rise) begin
            div_d = (div == DIV_LAST) ? '0 : div + DW'(1);
            pulse = (div == DIV_LAST);
         end
      end else if (state == RUN)
         state_d = btn_level ? WAIT_REL : IDLE;
      else if (state == IDLE && btn_rise) begin
         state_d = WAIT_REL;
         pulse   = 1'b1;
      end else if (state == WAIT_REL && !btn_level)
         state_d = IDLE;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state    <= IDLE;
         div      <= '0;
         cpu_en   <= 1'b0;
         step_cnt <= '0;
      end else begin
         state  <= state_d;
         div    <= div_d;
         cpu_en <= pulse;
         if (pulse)
            step_cnt <= step_cnt + 16'd1;
      end
endmodule

// File: tb/tb_step_ctrl.sv
// tb_step_ctrl: randomized and directed scoreboard bench for step_ctrl (DEBOUNCE_N=4, RUN_DIV=8).
module tb_step_ctrl;
   localparam int DN = 4;
   localparam int RD = 8;

   logic clk = 0, reset = 0, btn_step = 0, sw_run = 0;
   logic cpu_en, mode_run;
   logic [15:0] step_cnt;

   step_ctrl #(.DEBOUNCE_N(DN), .RUN_DIV(RD)) dut (
      .clk(clk), .reset(reset), .btn_step(btn_step), .sw_run(sw_run),
      .cpu_en(cpu_en), .step_cnt(step_cnt), .mode_run(mode_run)
   );

   always #5 clk = ~clk;

   typedef struct {int cyc; logic [15:0] cnt;} exp_t;
   exp_t sbq[$];
   int total = 0, bad = 0, cyc = 0, pulses = 0, first_pulse = -1;

   // behavioural model: input histories, debounced levels, run phase
   bit hb[$], hs[$];
   bit mb, ms, mrise, in_run, armed;
   int phase, mpulses = 0;
   logic [15:0] mcnt;
   logic due;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit all_differ(input bit q[$], input bit lvl);
      for (int i = 1; i <= DN; i++)
         if (q[i] == lvl) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      hb.delete();
      hs.delete();
      for (int i = 0; i <= DN; i++) begin
         hb.push_back(1'b0);
         hs.push_back(1'b0);
      end
      mb = 0; ms = 0; mrise = 0; in_run = 0; armed = 1; phase = 0; mcnt = 16'd0;
      sbq.delete();
   endtask

   task automatic model_step(input bit b, input bit s);
      bit p;
      p = 0;
      if (ms) begin
         if (in_run) begin
            p = (phase % RD) == RD - 1;
            phase++;
         end else begin
            in_run = 1;
            phase = 0;
         end
      end else if (in_run) begin
         in_run = 0;
         armed = !mb;
      end else if (armed) begin
         if (mrise) begin
            p = 1;
            armed = 0;
         end
      end else if (!mb)
         armed = 1;
      if (p) begin
         mcnt = mcnt + 16'd1;
         mpulses++;
         sbq.push_back('{cyc, mcnt});
      end
      mrise = 0;
      if (all_differ(hb, mb)) begin
         mb = !mb;
         mrise = mb;
      end
      if (all_differ(hs, ms)) ms = !ms;
      hb.push_front(b);
      void'(hb.pop_back());
      hs.push_front(s);
      void'(hs.pop_back());
   endtask

   task automatic tick(input bit b, input bit s);
      btn_step = b;
      sw_run = s;
      @(posedge clk);
      cyc++;
      model_step(b, s);
      #2;
      check("mode_run", mode_run, ms);
   endtask

   task automatic do_reset();
      reset = 1;
      #1;
      check("rst_cpu_en", cpu_en, 0);
      check("rst_step_cnt", step_cnt, 0);
      check("rst_mode_run", mode_run, 0);
      repeat (3) @(posedge clk);
      #2;
      model_reset();
      cyc = 0;
      first_pulse = -1;
      reset = 0;
   endtask

   always @(negedge clk)
      if (!reset) begin
         due = sbq.size() > 0 && sbq[0].cyc == cyc;
         check("cpu_en", cpu_en, due);
         if (cpu_en) begin
            pulses++;
            if (first_pulse < 0) first_pulse = cyc;
         end
         if (due) begin
            check("step_cnt", step_cnt, sbq[0].cnt);
            void'(sbq.pop_front());
         end
      end

   initial begin
      int p0, guard, n;
      bit b, s;
      model_reset();
      #1;
      do_reset();

      // single press held then released
      p0 = pulses;
      repeat (20) tick(1, 0);
      repeat (10) tick(0, 0);
      check("press_pulses", pulses - p0, 1);
      check("press_latency", first_pulse, 7);
      check("press_cnt", step_cnt, 1);

      // short glitches never pass the debouncer
      do_reset();
      p0 = pulses;
      repeat (10) begin
         repeat (3) tick(1, 0);
         repeat (3) tick(0, 0);
      end
      repeat (10) tick(0, 0);
      check("glitch_pulses", pulses - p0, 0);
      check("glitch_cnt", step_cnt, 0);

      // free run for 100 cycles
      do_reset();
      p0 = pulses;
      repeat (100) tick(0, 1);
      repeat (12) tick(0, 0);
      check("run_pulses", pulses - p0, 12);
      check("run_cnt", step_cnt, 12);
      check("run_first", first_pulse, 15);

      // counter wrap from 16'hFFFF
      do_reset();
      force dut.step_cnt = 16'hFFFF;
      #1;
      release dut.step_cnt;
      mcnt = 16'hFFFF;
      check("preload", step_cnt, 65535);
      repeat (8) tick(1, 0);
      repeat (8) tick(0, 0);
      check("wrap_cnt", step_cnt, 0);

      // reset mid-run with the divider at 5
      do_reset();
      p0 = mpulses;
      guard = 0;
      while (mpulses == p0 && guard < 40) begin
         tick(0, 1);
         guard++;
      end
      check("run_started", guard < 40, 1);
      repeat (5) tick(0, 1);
      do_reset();
      repeat (20) tick(0, 1);
      check("rst_run_first_late", first_pulse >= 14, 1);
      check("rst_run_cnt", step_cnt, 1);

      // leave run with the button held
      do_reset();
      repeat (12) tick(0, 1);
      repeat (10) tick(1, 1);
      repeat (10) tick(1, 0);
      p0 = pulses;
      repeat (30) tick(1, 0);
      check("held_no_pulse", pulses - p0, 0);
      repeat (10) tick(0, 0);
      p0 = pulses;
      repeat (10) tick(1, 0);
      repeat (5) tick(0, 0);
      check("repress_pulse", pulses - p0, 1);

      // randomized mix of presses, glitches, mode changes and resets
      do_reset();
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 40) == 0) do_reset();
         b = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 5) == 0) s = !s;
         n = $urandom_range(1, 14);
         repeat (n) tick(b, s);
      end
      repeat (20) tick(0, 0);
      check("sb_empty", sbq.size(), 0);
      check("final_cnt", step_cnt, mcnt);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/step_ctrl.md
STEP_CTRL -- requirements
Module: step_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_N, default 200000, meaning the number of clk cycles an input must be stable before it is accepted.
REQ-002 The block SHALL have parameter RUN_DIV, default 50000000, meaning the number of clk cycles between enable pulses in run mode.
REQ-003 clk  input  1  board clock; the only clock; all state is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 btn_step  input  1  raw, asynchronous single-step push button.
REQ-006 sw_run  input  1  raw, asynchronous mode switch; 1 = run mode, 0 = step mode.
REQ-007 cpu_en  output  1  one-clk-cycle advance pulse for the downstream processor.
REQ-008 step_cnt  output  16  number of cpu_en pulses issued since reset, for the display stage.
REQ-009 mode_run  output  1  debounced, registered copy of sw_run.

Function
REQ-010 Each raw input SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 A synchronized input SHALL be accepted as a new debounced level only after it differs from the current debounced level for DEBOUNCE_N consecutive cycles; any reversion SHALL restart the count at 0.
REQ-012 Step FSM states SHALL be IDLE, WAIT_REL and RUN.
REQ-013 In IDLE with mode_run=0, a debounced btn_step 0->1 edge SHALL assert cpu_en for exactly one cycle, in the cycle after the edge, and move to WAIT_REL.
REQ-014 WAIT_REL SHALL return to IDLE on a debounced btn_step 1->0 transition; holding the button SHALL never produce a second pulse.
REQ-015 In any state, mode_run=1 SHALL move to RUN on the next cycle and clear the run divider to 0.
REQ-016 In RUN, the divider SHALL count 0..RUN_DIV-1 and wrap; cpu_en SHALL pulse on the cycle the divider equals RUN_DIV-1; btn_step SHALL be ignored.
REQ-017 When mode_run falls to 0 in RUN, the FSM SHALL go to WAIT_REL if debounced btn_step=1, else to IDLE, with no pulse issued in the transition cycle.
REQ-018 If the divider-terminal event and the mode_run 1->0 change occur in the same cycle, the mode change SHALL win and no pulse SHALL be issued.
REQ-019 step_cnt SHALL increment by 1 in the same cycle cpu_en is high and wrap from 16'hFFFF to 16'h0000.
REQ-020 cpu_en SHALL be high for at most one cycle within any 2 consecutive cycles, in all modes and parameter settings with RUN_DIV >= 2.
REQ-021 All outputs SHALL be driven directly from flops.

Reset
REQ-022 Asserting reset SHALL immediately force cpu_en=0, step_cnt=0, mode_run=0, FSM=IDLE, the debounced levels to 0, the debounce counters to 0, the run divider to 0 and the synchronizers to 0.
REQ-023 Reset asserted during a debounce window or mid-RUN SHALL discard partial counts, and no cpu_en pulse SHALL be issued during reset or in the first cycle after it deasserts.
REQ-024 After reset deasserts, a button already held SHALL be accepted as a press only after DEBOUNCE_N stable cycles.

Structure
REQ-025 The FSM state encodings and the default DEBOUNCE_N and RUN_DIV values SHALL live in the shared defines include used by the display and top-level blocks.
REQ-026 Synchronizer plus debouncer SHALL be one sub-module, btn_debounce, parameterized by DEBOUNCE_N, with ports clk, reset, raw, level and rise, instanced twice.
REQ-027 step_ctrl SHALL replace direct use of reset as the processor clock and feed step_cnt or the processor-enable path alongside the display stage.

Verification (DEBOUNCE_N=4, RUN_DIV=8)
REQ-028 btn_step held high 20 cycles, then released -> exactly one cpu_en pulse, 6-7 cycles after the press (2 sync + 4 debounce + 1), and step_cnt=1.
REQ-029 btn_step with 3-cycle glitches repeated 10 times -> no cpu_en pulse and step_cnt=0.
REQ-030 sw_run=1 for 100 cycles -> a cpu_en pulse every 8 cycles, about 11-12 pulses, and step_cnt equal to the pulse count.
REQ-031 step_cnt preloaded by 65535 steps, then one more press -> step_cnt=0.
REQ-032 Reset asserted mid-RUN with the divider at 5 -> cpu_en=0 and step_cnt=0 immediately; after release with sw_run=1, the first pulse occurs no earlier than the 2 sync + 4 debounce + 8 divider cycles after release.
REQ-033 sw_run falling while btn_step is held -> FSM=WAIT_REL and no pulse until the button is released and pressed again.
